ppu_pipe_ctrl: RTL and testbench

//  Parametrised fetch and control-signal pipeline for the PPU: PC/nPC generation, IF/ID instruction register,
//  and ID/EX -> EX/MEM -> MEM/WB control-word registers with stall, flush, branch redirect and bubble insert.

---
 rtl/ppu_pkg.sv | 49 ++++
 rtl/ppu_stage_reg.sv | 20 ++
 rtl/ppu_pipe_ctrl.sv | 98 +++++++++
 tb/tb_ppu_pipe_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: control-word bit layout, default per-stage exposure masks,
// and opcode/funct encodings common to the control unit and the fetch/control pipeline.
package ppu_pkg;

  localparam int unsigned CW_W_DEF = 15;

  localparam int unsigned CW_MEM_EN  = 0;
  localparam int unsigned CW_LO      = 1;
  localparam int unsigned CW_HI      = 2;
  localparam int unsigned CW_SE      = 3;
  localparam int unsigned CW_RW      = 4;
  localparam int unsigned CW_SIZE_LO = 5;
  localparam int unsigned CW_SIZE_HI = 6;
  localparam int unsigned CW_TA      = 7;
  localparam int unsigned CW_B       = 8;
  localparam int unsigned CW_RF      = 9;
  localparam int unsigned CW_LOAD    = 10;
  localparam int unsigned CW_ALU_LO  = 11;
  localparam int unsigned CW_ALU_HI  = 13;
  localparam int unsigned CW_SHIFT   = 14;

  localparam logic [CW_W_DEF-1:0] EX_MASK_DEF  = 15'h7F80;
  localparam logic [CW_W_DEF-1:0] MEM_MASK_DEF = 15'h0679;
  localparam logic [CW_W_DEF-1:0] WB_MASK_DEF  = 15'h0606;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_MFHI = 6'h10,
    FN_MFLO = 6'h12,
    FN_MULT = 6'h18,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23
  } funct_t;

  function automatic logic [CW_W_DEF-1:0] cw_bit(input int unsigned idx);
    return CW_W_DEF'(1) << idx;
  endfunction

endpackage

// File: rtl/ppu_stage_reg.sv
// Pipeline register with async reset, synchronous clear (bubble/squash) and load enable.
// Clear wins over enable so a squash is never lost to a concurrent load.
module ppu_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ppu_pipe_ctrl.sv
// PPU fetch and control-word pipeline: PC/nPC generation, IF/ID instruction register and
// ID/EX -> EX/MEM -> MEM/WB control registers carrying a valid bit alongside the full word.
module ppu_pipe_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          CW_W     = CW_W_DEF,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4,
  parameter logic [CW_W-1:0]      EX_MASK  = CW_W'(EX_MASK_DEF),
  parameter logic [CW_W-1:0]      MEM_MASK = CW_W'(MEM_MASK_DEF),
  parameter logic [CW_W-1:0]      WB_MASK  = CW_W'(WB_MASK_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic [CW_W-1:0]   id_ctrl,
  input  logic [31:0]       instr_in,
  input  logic              le_pc,
  input  logic              le_npc,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic [31:0]       if_id_instr,
  output logic [CW_W-1:0]   ex_ctrl,
  output logic [CW_W-1:0]   mem_ctrl,
  output logic [CW_W-1:0]   wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] npc_reg;

  // Redirect takes effect even while fetch is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg  <= RESET_PC;
      npc_reg <= RESET_PC + STEP;
    end else begin
      if (branch_taken) pc_reg <= branch_target;
      else if (le_pc)   pc_reg <= npc_reg;

      if (branch_taken) npc_reg <= branch_target + STEP;
      else if (le_npc)  npc_reg <= npc_reg + STEP;
    end
  end

  assign pc  = pc_reg;
  assign npc = npc_reg;

  ppu_stage_reg #(.W(32)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (le_pc),
    .clr   (flush | branch_taken),
    .d     (instr_in),
    .q     (if_id_instr)
  );

  // Index 0 is ID/EX, 1 is EX/MEM, 2 is MEM/WB; the MSB of each entry is the valid bit.
  logic [CW_W:0] stage_word [3];

  ppu_stage_reg #(.W(CW_W + 1)) u_id_ex (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (flush | ~s_sel | ~le_pc),
    .d     ({1'b1, id_ctrl}),
    .q     (stage_word[0])
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_back_stage
      ppu_stage_reg #(.W(CW_W + 1)) u_stage (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (stage_word[gi]),
        .q     (stage_word[gi+1])
      );
    end
  endgenerate

  assign ex_ctrl   = stage_word[0][CW_W-1:0] & EX_MASK;
  assign mem_ctrl  = stage_word[1][CW_W-1:0] & MEM_MASK;
  assign wb_ctrl   = stage_word[2][CW_W-1:0] & WB_MASK;
  assign ex_valid  = stage_word[0][CW_W];
  assign mem_valid = stage_word[1][CW_W];
  assign wb_valid  = stage_word[2][CW_W];

endmodule

// File: tb/tb_ppu_pipe_ctrl.sv
// Directed bench for ppu_pipe_ctrl: hand-computed PC/nPC, IF/ID and per-stage control
// expectations across reset, streaming, bubbles, stalls, redirects, flushes and wrap-around.
module tb_ppu_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_sel;
  logic [14:0] id_ctrl;
  logic [31:0] instr_in;
  logic        le_pc;
  logic        le_npc;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] if_id_instr;
  logic [14:0] ex_ctrl;
  logic [14:0] mem_ctrl;
  logic [14:0] wb_ctrl;
  logic        ex_valid;
  logic        mem_valid;
  logic        wb_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_pipe_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .s_sel         (s_sel),
    .id_ctrl       (id_ctrl),
    .instr_in      (instr_in),
    .le_pc         (le_pc),
    .le_npc        (le_npc),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .npc           (npc),
    .if_id_instr   (if_id_instr),
    .ex_ctrl       (ex_ctrl),
    .mem_ctrl      (mem_ctrl),
    .wb_ctrl       (wb_ctrl),
    .ex_valid      (ex_valid),
    .mem_valid     (mem_valid),
    .wb_valid      (wb_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pipe(input string tag,
                             input logic [31:0] e_pc, input logic [31:0] e_npc,
                             input logic [31:0] e_ifid,
                             input logic [14:0] e_ex,  input logic e_exv,
                             input logic [14:0] e_mem, input logic e_memv,
                             input logic [14:0] e_wb,  input logic e_wbv);
    $display("txn %-10s pc=%h npc=%h ifid=%h ex=%h/%b mem=%h/%b wb=%h/%b", tag, pc, npc,
             if_id_instr, ex_ctrl, ex_valid, mem_ctrl, mem_valid, wb_ctrl, wb_valid);
    chk({tag, ".pc"},   pc, e_pc);
    chk({tag, ".npc"},  npc, e_npc);
    chk({tag, ".ifid"}, if_id_instr, e_ifid);
    chk({tag, ".ex"},   32'(ex_ctrl), 32'(e_ex));
    chk({tag, ".exv"},  32'(ex_valid), 32'(e_exv));
    chk({tag, ".mem"},  32'(mem_ctrl), 32'(e_mem));
    chk({tag, ".memv"}, 32'(mem_valid), 32'(e_memv));
    chk({tag, ".wb"},   32'(wb_ctrl), 32'(e_wb));
    chk({tag, ".wbv"},  32'(wb_valid), 32'(e_wbv));
  endtask

  initial begin
    reset = 1'b1; s_sel = 1'b0; id_ctrl = '0; instr_in = '0;
    le_pc = 1'b0; le_npc = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // reset state
    step(); step();
    expect_pipe("reset", 32'h0, 32'h4, 32'h0, 15'h0, 0, 15'h0, 0, 15'h0, 0);
    reset = 1'b0;

    // full word streams through, each stage shows its own mask
    s_sel = 1'b1; id_ctrl = 15'h7FFF; le_pc = 1'b1; le_npc = 1'b1;
    instr_in = 32'h1111_1111; step();
    expect_pipe("stream1", 32'h4, 32'h8, 32'h1111_1111, 15'h7F80, 1, 15'h0, 0, 15'h0, 0);
    instr_in = 32'h2222_2222; step();
    expect_pipe("stream2", 32'h8, 32'hC, 32'h2222_2222, 15'h7F80, 1, 15'h0679, 1, 15'h0, 0);
    instr_in = 32'h3333_3333; step();
    expect_pipe("stream3", 32'hC, 32'h10, 32'h3333_3333, 15'h7F80, 1, 15'h0679, 1, 15'h0606, 1);

    // s_sel=0 bubbles while fetch keeps advancing
    s_sel = 1'b0; instr_in = 32'h4444_4444; step();
    expect_pipe("bubble1", 32'h10, 32'h14, 32'h4444_4444, 15'h0, 0, 15'h0679, 1, 15'h0606, 1);
    step();
    expect_pipe("bubble2", 32'h14, 32'h18, 32'h4444_4444, 15'h0, 0, 15'h0, 0, 15'h0606, 1);
    step();
    expect_pipe("bubble3", 32'h18, 32'h1C, 32'h4444_4444, 15'h0, 0, 15'h0, 0, 15'h0, 0);

    // word whose EX-hidden bits must still appear at MEM/WB, then a 2-cycle stall
    s_sel = 1'b1; id_ctrl = 15'h1234; instr_in = 32'h7777_7777; step();
    expect_pipe("pre_stall", 32'h1C, 32'h20, 32'h7777_7777, 15'h1200, 1, 15'h0, 0, 15'h0, 0);
    le_pc = 1'b0; le_npc = 1'b0; id_ctrl = 15'h7FFF; instr_in = 32'hDEAD_BEEF; step();
    expect_pipe("stall1", 32'h1C, 32'h20, 32'h7777_7777, 15'h0, 0, 15'h0230, 1, 15'h0, 0);
    step();
    expect_pipe("stall2", 32'h1C, 32'h20, 32'h7777_7777, 15'h0, 0, 15'h0, 0, 15'h0204, 1);
    le_pc = 1'b1; le_npc = 1'b1; step();
    expect_pipe("resume1", 32'h20, 32'h24, 32'hDEAD_BEEF, 15'h7F80, 1, 15'h0, 0, 15'h0, 0);
    step();
    expect_pipe("resume2", 32'h24, 32'h28, 32'hDEAD_BEEF, 15'h7F80, 1, 15'h0679, 1, 15'h0, 0);

    // branch overrides a stalled PC
    branch_taken = 1'b1; branch_target = 32'h40; le_pc = 1'b0; le_npc = 1'b0; step();
    expect_pipe("br_stall", 32'h40, 32'h44, 32'h0, 15'h0, 0, 15'h0679, 1, 15'h0606, 1);
    // branch together with flush
    flush = 1'b1; branch_target = 32'h80; le_pc = 1'b1; le_npc = 1'b1; step();
    expect_pipe("br_flush", 32'h80, 32'h84, 32'h0, 15'h0, 0, 15'h0, 0, 15'h0606, 1);
    branch_taken = 1'b0; step();
    expect_pipe("flush", 32'h84, 32'h88, 32'h0, 15'h0, 0, 15'h0, 0, 15'h0, 0);

    // nPC wrap-around
    flush = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8; instr_in = 32'h5555_5555; step();
    expect_pipe("wrap0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 15'h7F80, 1, 15'h0, 0, 15'h0, 0);
    branch_taken = 1'b0; step();
    expect_pipe("wrap1", 32'hFFFF_FFFC, 32'h0, 32'h5555_5555, 15'h7F80, 1, 15'h0679, 1, 15'h0, 0);
    step();
    expect_pipe("wrap2", 32'h0, 32'h4, 32'h5555_5555, 15'h7F80, 1, 15'h0679, 1, 15'h0606, 1);

    // nPC advances on its own enable while PC holds
    le_pc = 1'b0; step();
    expect_pipe("npc_only", 32'h0, 32'h8, 32'h5555_5555, 15'h0, 0, 15'h0679, 1, 15'h0606, 1);
    le_pc = 1'b1; step();
    expect_pipe("pc_catch", 32'h8, 32'hC, 32'h5555_5555, 15'h7F80, 1, 15'h0, 0, 15'h0606, 1);

    // asynchronous reset mid-cycle during a flush
    flush = 1'b1; #2; reset = 1'b1; #1;
    expect_pipe("async_rst", 32'h0, 32'h4, 32'h0, 15'h0, 0, 15'h0, 0, 15'h0, 0);
    step();
    expect_pipe("rst_hold", 32'h0, 32'h4, 32'h0, 15'h0, 0, 15'h0, 0, 15'h0, 0);
    reset = 1'b0; flush = 1'b0; step();
    expect_pipe("post_rst", 32'h4, 32'h8, 32'h5555_5555, 15'h7F80, 1, 15'h0, 0, 15'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
